ysyx_22050133_mem_arb: RTL
==========================

YSYX_22050133_MEM_ARB -- requirements
Module: ysyx_22050133_mem_arb

Interface
REQ-001 SHALL have parameter AW, 64, address width.
REQ-002 SHALL have parameter DW, 64, data width; the write mask width is DW/8.
REQ-003 SHALL have parameter STREAK_MAX, 2, the number of consecutive LS grants allowed while an IF request is pending.
REQ-004 clk  in  1  the single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req_valid  in  1  instruction fetch request.
REQ-007 if_req_ready  out  1  fetch request accepted.
REQ-008 if_addr  in  AW  fetch address.
REQ-009 if_resp_valid  out  1  fetch data valid, one-cycle pulse.
REQ-010 if_rdata  out  DW  fetch data.
REQ-011 ls_req_valid  in  1  load/store request.
REQ-012 ls_req_ready  out  1  load/store request accepted.
REQ-013 ls_addr  in  AW  load/store address.
REQ-014 ls_wen  in  1  1=store, 0=load.
REQ-015 ls_wdata  in  DW  store data.
REQ-016 ls_wmask  in  DW/8  byte-enable mask.
REQ-017 ls_resp_valid  out  1  load data or store acknowledge, one-cycle pulse.
REQ-018 ls_rdata  out  DW  load data.
REQ-019 flush  in  1  pipeline redirect; cancels fetch.
REQ-020 mem_req_valid, mem_req_ready  out/in  1  memory request handshake.
REQ-021 mem_addr, mem_wen, mem_wdata, mem_wmask  out  AW/1/DW/DW/8  registered request fields.
REQ-022 mem_resp_valid, mem_rdata  in  1/DW  memory response.

Function
REQ-023 SHALL keep at most one memory transaction outstanding, sequenced by an FSM with states IDLE, ISSUE and WAIT.
REQ-024 IDLE: SHALL assert at most one of if_req_ready and ls_req_ready, combinationally, only in IDLE; a request is accepted when valid&ready.
REQ-025 Arbitration: LS SHALL win over IF, except that when streak==STREAK_MAX and if_req_valid is high, IF SHALL win.
REQ-026 streak SHALL increment on an LS grant while if_req_valid is high, saturate at STREAK_MAX, and clear on any IF grant or when if_req_valid is low in IDLE.
REQ-027 On acceptance, SHALL latch the address, wen, wdata, wmask and owner (IF grants latch wen=0 and wmask=0) and go to ISSUE on the next cycle.
REQ-028 ISSUE: SHALL hold mem_req_valid=1 with stable latched fields until mem_req_ready, then go to WAIT.
REQ-029 WAIT: on mem_resp_valid, SHALL pulse the owner's resp_valid in the same cycle, pass mem_rdata through to the owner's rdata, and return to IDLE.
REQ-030 Minimum latency SHALL be accept at cycle N, mem_req_valid at N+1, response no earlier than N+2.
REQ-031 A store SHALL also wait for mem_resp_valid; ls_resp_valid pulses as the acknowledge, and ls_rdata is don't-care.
REQ-032 flush in IDLE SHALL force if_req_ready=0 for that cycle; LS arbitration is unaffected.
REQ-033 flush while owner=IF in ISSUE or WAIT SHALL set a drop flag; the memory transaction completes, but if_resp_valid stays 0 and the FSM returns to IDLE normally.
REQ-034 flush SHALL have no effect on an LS-owned transaction.
REQ-035 mem_resp_valid in IDLE or ISSUE SHALL be ignored.
REQ-036 A new request SHALL NOT be accepted in the same cycle as a response; the earliest back-to-back accept is the cycle after the response.
REQ-037 rdata outputs SHALL be 0 when the matching resp_valid is 0.

Reset
REQ-038 On rst: state=IDLE, streak=0, drop=0, owner=LS; all valid/ready outputs 0; mem_addr, mem_wdata, mem_wmask, mem_wen 0.
REQ-039 rst asserted mid-transaction SHALL abandon it with no response pulse; the first accept is possible in the first cycle after rst deasserts.

Verification
REQ-040 Single fetch, mem ready and response 1 cycle after issue: if_addr=0x80000000 accepted at cycle 0 -> mem_req_valid at cycle 1, if_resp_valid and if_rdata=mem_rdata at cycle 2.
REQ-041 if and ls valid in the same IDLE cycle -> ls_req_ready=1, if_req_ready=0; the IF request is granted after the LS response.
REQ-042 Continuous LS and IF requests, STREAK_MAX=2 -> grant order LS, LS, IF, LS, LS, IF.
REQ-043 Store with ls_wdata=0x1122334455667788 and ls_wmask=0x0F, mem_req_ready held low 3 cycles -> fields stable throughout ISSUE; ls_resp_valid pulses on the memory acknowledge.
REQ-044 flush during IF WAIT -> no if_resp_valid; the next LS request is accepted the cycle after mem_resp_valid.
REQ-045 rst during WAIT, then a late mem_resp_valid -> no resp pulse; all outputs at reset values.

Source files
------------

// File: rtl/ysyx_22050133_mem_arb_if.sv
//------------------------------------------------------------------------------
// Module      : ysyx_22050133_mem_arb_if
// Description : Fetch, load/store and memory-side bus for the memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ysyx_22050133_mem_arb_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            if_req_valid;
  logic            if_req_ready;
  logic [AW-1:0]   if_addr;
  logic            if_resp_valid;
  logic [DW-1:0]   if_rdata;

  logic            ls_req_valid;
  logic            ls_req_ready;
  logic [AW-1:0]   ls_addr;
  logic            ls_wen;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wmask;
  logic            ls_resp_valid;
  logic [DW-1:0]   ls_rdata;

  logic            flush;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  flush, mem_req_ready, mem_resp_valid, mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  // Requesters and memory side
  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output flush, mem_req_ready, mem_resp_valid, mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050133_mem_arb.sv
//------------------------------------------------------------------------------
// Module      : ysyx_22050133_mem_arb
// Description : Single-outstanding memory arbiter between fetch and load/store.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_22050133_mem_arb #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STREAK_MAX = 2
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22050133_mem_arb_if.slave bus_io
);

  localparam int c_streak_w = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [c_streak_w-1:0] c_streak_top = c_streak_w'(STREAK_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [c_streak_w-1:0] streak_q, streak_d;
  logic                  drop_q, drop_d;
  logic                  owner_if_q, owner_if_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW/8-1:0]       wmask_q, wmask_d;

  logic w_streak_full;
  logic w_if_ready;
  logic w_ls_ready;
  logic w_if_resp;
  logic w_ls_resp;
  logic w_mem_req_valid;

  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    drop_d          = drop_q;
    owner_if_d      = owner_if_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    w_if_ready      = 1'b0;
    w_ls_ready      = 1'b0;
    w_if_resp       = 1'b0;
    w_ls_resp       = 1'b0;
    w_mem_req_valid = 1'b0;
    w_streak_full   = (streak_q == c_streak_top);

    case (state_q)
      S_IDLE: begin
        // Fetch only overtakes load/store once the streak budget is used up.
        w_ls_ready = bus_io.ls_req_valid && !(bus_io.if_req_valid && w_streak_full);
        w_if_ready = bus_io.if_req_valid && !bus_io.flush &&
                     (!bus_io.ls_req_valid || w_streak_full);
        if (w_ls_ready && !rst) begin
          state_d    = S_ISSUE;
          owner_if_d = 1'b0;
          drop_d     = 1'b0;
          addr_d     = bus_io.ls_addr;
          wen_d      = bus_io.ls_wen;
          wdata_d    = bus_io.ls_wdata;
          wmask_d    = bus_io.ls_wmask;
          if (!bus_io.if_req_valid) begin
            streak_d = '0;
          end else if (!w_streak_full) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (w_if_ready && !rst) begin
          state_d    = S_ISSUE;
          owner_if_d = 1'b1;
          drop_d     = 1'b0;
          addr_d     = bus_io.if_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
          streak_d   = '0;
        end else if (!bus_io.if_req_valid) begin
          streak_d = '0;
        end
      end
      S_ISSUE: begin
        w_mem_req_valid = 1'b1;
        if (bus_io.flush && owner_if_q) drop_d = 1'b1;
        if (bus_io.mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_io.flush && owner_if_q) drop_d = 1'b1;
        if (bus_io.mem_resp_valid) begin
          // A flush landing on the response cycle still cancels the fetch.
          w_if_resp = owner_if_q && !drop_q && !bus_io.flush;
          w_ls_resp = !owner_if_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      w_if_ready      = 1'b0;
      w_ls_ready      = 1'b0;
      w_if_resp       = 1'b0;
      w_ls_resp       = 1'b0;
      w_mem_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      streak_q   <= '0;
      drop_q     <= 1'b0;
      owner_if_q <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      drop_q     <= drop_d;
      owner_if_q <= owner_if_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
    end
  end

  assign bus_io.if_req_ready  = w_if_ready;
  assign bus_io.ls_req_ready  = w_ls_ready;
  assign bus_io.if_resp_valid = w_if_resp;
  assign bus_io.ls_resp_valid = w_ls_resp;
  assign bus_io.if_rdata      = w_if_resp ? bus_io.mem_rdata : '0;
  assign bus_io.ls_rdata      = w_ls_resp ? bus_io.mem_rdata : '0;
  assign bus_io.mem_req_valid = w_mem_req_valid;
  assign bus_io.mem_addr      = addr_q;
  assign bus_io.mem_wen       = wen_q;
  assign bus_io.mem_wdata     = wdata_q;
  assign bus_io.mem_wmask     = wmask_q;

endmodule

`default_nettype wire
